// File: rtl/delay_pkg.sv
// Shared definitions for the programmable data delay line.
// Contents:
//   clog2()          - ceiling log2, used to size the tap select
//   DEF_BITS         - default sample width
//   DEF_MAX_DELAY    - default number of register stages
package delay_pkg;

    localparam int DEF_BITS      = 8;
    localparam int DEF_MAX_DELAY = 16;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/prog_data_delay_if.sv
// Bus bundle for prog_data_delay.
// Ports (as seen from the delay line, modport slave):
//   i_Din, i_valid      - sample and its qualifier
//   i_en, i_flush       - advance enable, synchronous invalidate
//   i_sel, i_sel_wr     - requested delay and its load strobe
//   o_Dout, o_valid     - sample/valid at the selected tap
//   o_Taps              - every stage output, stage k at [k*BITS-1:(k-1)*BITS]
//   o_primed, o_sel_err - fill reached the active delay, sticky bad-select flag
// modport master is the driving side (stimulus / upstream logic).
interface prog_data_delay_if
    import delay_pkg::*;
#(
    parameter int BITS      = DEF_BITS,
    parameter int MAX_DELAY = DEF_MAX_DELAY,
    parameter int SW        = clog2(MAX_DELAY + 1)
);

    logic [BITS-1:0]           i_Din;
    logic                      i_valid;
    logic                      i_en;
    logic                      i_flush;
    logic [SW-1:0]             i_sel;
    logic                      i_sel_wr;
    logic [BITS-1:0]           o_Dout;
    logic                      o_valid;
    logic [MAX_DELAY*BITS-1:0] o_Taps;
    logic                      o_primed;
    logic                      o_sel_err;

    modport slave (
        input  i_Din, i_valid, i_en, i_flush, i_sel, i_sel_wr,
        output o_Dout, o_valid, o_Taps, o_primed, o_sel_err
    );

    modport master (
        output i_Din, i_valid, i_en, i_flush, i_sel, i_sel_wr,
        input  o_Dout, o_valid, o_Taps, o_primed, o_sel_err
    );

endinterface

// File: rtl/delay_stage.sv
// One stage of the delay line: a BITS-wide data register plus a valid bit.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   en            - load d_in/v_in on this edge
//   flush         - clear the valid bit; data is left untouched
//   d_in, v_in    - data/valid from the previous stage (or the line input)
//   d_out, v_out  - registered data/valid
module delay_stage #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            flush,
    input  logic [BITS-1:0] d_in,
    input  logic            v_in,
    output logic [BITS-1:0] d_out,
    output logic            v_out
);

    logic [BITS-1:0] data_p1;
    logic            vld_p1;

    // Stage register: flush invalidates without moving data, even when enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else if (flush) begin
            vld_p1  <= 1'b0;
        end else if (en) begin
            data_p1 <= d_in;
            vld_p1  <= v_in;
        end
    end

    assign d_out = data_p1;
    assign v_out = vld_p1;

endmodule

// File: rtl/prog_data_delay.sv
// Programmable-length delay line: MAX_DELAY chained stages with a runtime
// selectable output tap.
// Ports:
//   i_clk, i_rst - clock, asynchronous active-high reset
//   bus          - prog_data_delay_if.slave (sample in, enable, flush,
//                  tap select in; selected tap, all taps, status out)
// r_sel picks the tap (1..MAX_DELAY), r_fill counts enabled edges since the
// last flush/reset (saturating), r_sel_err latches an out-of-range select.
module prog_data_delay
    import delay_pkg::*;
#(
    parameter int BITS      = DEF_BITS,
    parameter int MAX_DELAY = DEF_MAX_DELAY,
    parameter int RST_DELAY = MAX_DELAY
) (
    input  logic               i_clk,
    input  logic               i_rst,
    prog_data_delay_if.slave   bus
);

    localparam int            SW      = clog2(MAX_DELAY + 1);
    localparam logic [SW-1:0] MAX_SEL = SW'(MAX_DELAY);
    localparam logic [SW-1:0] RST_SEL = SW'(RST_DELAY);

    // Index 0 is the line input, index k is the output of stage k.
    logic [MAX_DELAY:0][BITS-1:0] stage_d;
    logic [MAX_DELAY:0]           stage_v;

    logic [SW-1:0]   r_sel;
    logic [SW-1:0]   r_fill;
    logic            r_sel_err;
    logic            sel_ok;
    logic [BITS-1:0] tap_d;
    logic            tap_v;

    assign stage_d[0] = bus.i_Din;
    assign stage_v[0] = bus.i_valid;

    for (genvar k = 1; k <= MAX_DELAY; k++) begin : g_stage
        delay_stage #(
            .BITS (BITS)
        ) u_stage (
            .clk   (i_clk),
            .rst   (i_rst),
            .en    (bus.i_en),
            .flush (bus.i_flush),
            .d_in  (stage_d[k-1]),
            .v_in  (stage_v[k-1]),
            .d_out (stage_d[k]),
            .v_out (stage_v[k])
        );
    end

    // Packed layout already places stage 1 in the low BITS bits.
    assign bus.o_Taps = stage_d[MAX_DELAY:1];

    assign sel_ok = (bus.i_sel != '0) && (bus.i_sel <= MAX_SEL);

    // Control state. An illegal write in the same edge as a flush still
    // raises the error flag, since the write is honoured alongside the flush.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sel     <= RST_SEL;
            r_fill    <= '0;
            r_sel_err <= 1'b0;
        end else begin
            if (bus.i_flush) begin
                r_fill <= '0;
            end else if (bus.i_en && (r_fill != MAX_SEL)) begin
                r_fill <= r_fill + SW'(1);
            end

            if (bus.i_sel_wr && sel_ok) begin
                r_sel <= bus.i_sel;
            end

            if (bus.i_sel_wr && !sel_ok) begin
                r_sel_err <= 1'b1;
            end else if (bus.i_flush) begin
                r_sel_err <= 1'b0;
            end
        end
    end

    // Output tap mux; r_sel is always kept within 1..MAX_DELAY.
    always_comb begin
        tap_d = '0;
        tap_v = 1'b0;
        for (int k = 1; k <= MAX_DELAY; k++) begin
            if (r_sel == SW'(k)) begin
                tap_d = stage_d[k];
                tap_v = stage_v[k];
            end
        end
    end

    assign bus.o_Dout    = tap_d;
    assign bus.o_valid   = tap_v;
    assign bus.o_primed  = (r_fill >= r_sel);
    assign bus.o_sel_err = r_sel_err;

endmodule

// File: tb/tb_prog_data_delay.sv
// Testbench for prog_data_delay (BITS=8, MAX_DELAY=16, RST_DELAY=4).
module tb_prog_data_delay;

    localparam int BITS = 8;
    localparam int MAXD = 16;
    localparam int RSTD = 4;
    localparam int SW   = 5;

    logic i_clk = 1'b0;
    logic i_rst;

    always #5 i_clk = ~i_clk;

    prog_data_delay_if #(.BITS(BITS), .MAX_DELAY(MAXD)) bus ();

    prog_data_delay #(
        .BITS      (BITS),
        .MAX_DELAY (MAXD),
        .RST_DELAY (RSTD)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the line is a history of accepted samples, newest
    // first; stage k holds the entry pushed k enabled edges ago.
    typedef struct {
        logic [BITS-1:0] d;
        bit              v;
    } ent_t;

    ent_t hist[$];
    int   m_sel;
    int   m_fill;
    bit   m_err;

    task automatic model_reset();
        ent_t e;
        e.d = '0;
        e.v = 1'b0;
        hist.delete();
        for (int i = 0; i < MAXD; i++) hist.push_back(e);
        m_sel  = RSTD;
        m_fill = 0;
        m_err  = 1'b0;
    endtask

    task automatic model_edge(input bit en, input bit valid, input logic [BITS-1:0] din,
                              input bit flush, input bit sel_wr, input int sel);
        ent_t e;
        if (flush) begin
            for (int i = 0; i < MAXD; i++) hist[i].v = 1'b0;
            m_fill = 0;
            m_err  = 1'b0;
        end else if (en) begin
            e.d = din;
            e.v = valid;
            hist.push_front(e);
            void'(hist.pop_back());
            m_fill = (m_fill < MAXD) ? m_fill + 1 : MAXD;
        end
        if (sel_wr) begin
            if (sel >= 1 && sel <= MAXD) m_sel = sel;
            else m_err = 1'b1;
        end
    endtask

    task automatic check_model(input string tag);
        logic [MAXD*BITS-1:0] exp_taps;
        for (int k = 0; k < MAXD; k++) exp_taps[k*BITS +: BITS] = hist[k].d;
        check({tag, ".dout"},   bus.o_Dout,    hist[m_sel-1].d);
        check({tag, ".valid"},  bus.o_valid,   hist[m_sel-1].v);
        check({tag, ".primed"}, bus.o_primed,  (m_fill >= m_sel));
        check({tag, ".err"},    bus.o_sel_err, m_err);
        check({tag, ".taps"},   bus.o_Taps,    exp_taps);
    endtask

    // Drive one cycle, advance the model on the edge, then settle past it.
    task automatic drive(input bit en, input bit valid, input logic [BITS-1:0] din,
                         input bit flush, input bit sel_wr, input logic [SW-1:0] sel);
        bus.i_en     = en;
        bus.i_valid  = valid;
        bus.i_Din    = din;
        bus.i_flush  = flush;
        bus.i_sel_wr = sel_wr;
        bus.i_sel    = sel;
        @(posedge i_clk);
        model_edge(en, valid, din, flush, sel_wr, int'(sel));
        #1;
    endtask

    typedef struct {
        bit              en;
        bit              valid;
        bit              flush;
        bit              sel_wr;
        logic [SW-1:0]   sel;
        logic [BITS-1:0] din;
        logic [BITS-1:0] e_dout;
        bit              e_valid;
        bit              e_primed;
        bit              e_err;
    } vec_t;

    vec_t tbl[16];

    initial begin
        // en valid flush wr sel din | dout valid primed err
        tbl[0]  = '{1, 1, 0, 0, 5'd0,  8'h01, 8'h00, 0, 0, 0};
        tbl[1]  = '{1, 1, 0, 0, 5'd0,  8'h02, 8'h00, 0, 0, 0};
        tbl[2]  = '{1, 1, 0, 0, 5'd0,  8'h03, 8'h00, 0, 0, 0};
        tbl[3]  = '{1, 1, 0, 0, 5'd0,  8'h04, 8'h01, 1, 1, 0};
        tbl[4]  = '{1, 1, 0, 0, 5'd0,  8'h05, 8'h02, 1, 1, 0};
        tbl[5]  = '{0, 1, 0, 0, 5'd0,  8'h06, 8'h02, 1, 1, 0};
        tbl[6]  = '{0, 1, 0, 0, 5'd0,  8'h06, 8'h02, 1, 1, 0};
        tbl[7]  = '{0, 1, 0, 0, 5'd0,  8'h06, 8'h02, 1, 1, 0};
        tbl[8]  = '{1, 1, 0, 0, 5'd0,  8'h06, 8'h03, 1, 1, 0};
        tbl[9]  = '{1, 1, 0, 1, 5'd9,  8'h07, 8'h00, 0, 0, 0};
        tbl[10] = '{1, 1, 0, 1, 5'd0,  8'h08, 8'h00, 0, 0, 1};
        tbl[11] = '{1, 1, 0, 0, 5'd0,  8'h09, 8'h01, 1, 1, 1};
        tbl[12] = '{1, 1, 0, 0, 5'd0,  8'h0A, 8'h02, 1, 1, 1};
        tbl[13] = '{1, 1, 1, 0, 5'd0,  8'hAA, 8'h02, 0, 0, 0};
        tbl[14] = '{1, 1, 0, 0, 5'd0,  8'h0B, 8'h03, 0, 0, 0};
        tbl[15] = '{1, 1, 0, 1, 5'd17, 8'h0C, 8'h04, 0, 0, 1};

        bus.i_en     = 1'b0;
        bus.i_valid  = 1'b0;
        bus.i_Din    = '0;
        bus.i_flush  = 1'b0;
        bus.i_sel_wr = 1'b0;
        bus.i_sel    = '0;
        i_rst        = 1'b1;
        model_reset();

        // Outputs while held in reset
        #1;
        check("rst.dout",   bus.o_Dout,    8'h00);
        check("rst.valid",  bus.o_valid,   1'b0);
        check("rst.taps",   bus.o_Taps,    128'h0);
        check("rst.primed", bus.o_primed,  1'b0);
        check("rst.err",    bus.o_sel_err, 1'b0);
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Table: latency, stall, select switching, illegal select, flush
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].en, tbl[i].valid, tbl[i].din, tbl[i].flush, tbl[i].sel_wr, tbl[i].sel);
            check($sformatf("tbl%0d.dout", i),   bus.o_Dout,    tbl[i].e_dout);
            check($sformatf("tbl%0d.valid", i),  bus.o_valid,   tbl[i].e_valid);
            check($sformatf("tbl%0d.primed", i), bus.o_primed,  tbl[i].e_primed);
            check($sformatf("tbl%0d.err", i),    bus.o_sel_err, tbl[i].e_err);
            check_model($sformatf("tbl%0d.m", i));
        end

        // Asynchronous reset between edges, with tap 9 and data in flight
        #2;
        i_rst = 1'b1;
        #1;
        check("mrst.dout",   bus.o_Dout,    8'h00);
        check("mrst.valid",  bus.o_valid,   1'b0);
        check("mrst.taps",   bus.o_Taps,    128'h0);
        check("mrst.primed", bus.o_primed,  1'b0);
        check("mrst.err",    bus.o_sel_err, 1'b0);
        @(negedge i_clk);
        i_rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, 8'h50 + 8'(i), 1'b0, 1'b0, '0);
            check($sformatf("mrst_fill%0d.primed", i), bus.o_primed, (i == 3));
        end
        check("mrst_tap.dout",  bus.o_Dout,  8'h50);
        check("mrst_tap.valid", bus.o_valid, 1'b1);
        check_model("mrst.m");

        // Saturation: 40 enabled edges at delay 16
        for (int i = 1; i <= 40; i++) begin
            drive(1'b1, 1'b1, 8'(i), 1'b0, (i == 1), 5'd16);
        end
        for (int k = 1; k <= MAXD; k++) begin
            check($sformatf("sat.tap%0d", k), bus.o_Taps[(k-1)*BITS +: BITS], 8'(41 - k));
        end
        check("sat.primed", bus.o_primed, 1'b1);
        check("sat.dout",   bus.o_Dout,   8'd25);
        check_model("sat.m");

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 3) != 0),
                  $urandom_range(0, 1),
                  8'($urandom),
                  ($urandom_range(0, 15) == 0),
                  ($urandom_range(0, 7) == 0),
                  5'($urandom_range(0, 18)));
            check_model($sformatf("rnd%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_data_delay.md
PROG_DATA_DELAY -- requirements
Module: prog_data_delay

Interface
REQ-001 SHALL have parameter BITS, default 8: data width per sample.
REQ-002 SHALL have parameter MAX_DELAY, default 16: number of register stages (at least 2).
REQ-003 SHALL have parameter RST_DELAY, default MAX_DELAY: selected delay after reset (1..MAX_DELAY).
REQ-004 SHALL define SW = clog2(MAX_DELAY+1) as the select width.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port i_Din, input, BITS: sample in.
REQ-008 SHALL have port i_valid, input, 1 bit: i_Din qualifier.
REQ-009 SHALL have port i_en, input, 1 bit: pipeline advance enable; 0 stalls all stages.
REQ-010 SHALL have port i_flush, input, 1 bit: synchronous invalidate of all stages.
REQ-011 SHALL have port i_sel, input, SW bits: requested delay.
REQ-012 SHALL have port i_sel_wr, input, 1 bit: load strobe for i_sel.
REQ-013 SHALL have port o_Dout, output, BITS: sample at the selected tap.
REQ-014 SHALL have port o_valid, output, 1 bit: valid bit at the selected tap.
REQ-015 SHALL have port o_Taps, output, MAX_DELAY*BITS: all stage outputs; stage k occupies bits [k*BITS-1 : (k-1)*BITS].
REQ-016 SHALL have port o_primed, output, 1 bit: the fill count has reached the active delay.
REQ-017 SHALL have port o_sel_err, output, 1 bit: sticky flag for an illegal select.

Function
REQ-018 SHALL implement stage k (1..MAX_DELAY) as a BITS data register plus a 1-bit valid register.
- Stage 1 loads i_Din / i_valid.
- Stage k loads stage k-1.
- Loading occurs only on edges where i_en=1.
REQ-019 SHALL hold every data and valid register unchanged on edges where i_en=0.
REQ-020 SHALL drive o_Dout/o_valid combinationally from stage r_sel.
- Latency = r_sel enabled edges.
- With i_en held at 1, a sample presented before edge t appears after edge t+r_sel-1.
REQ-021 SHALL load r_sel from i_sel on an edge with i_sel_wr=1, regardless of i_en; the new tap drives outputs from the following cycle.
REQ-022 SHALL handle i_sel=0 or i_sel>MAX_DELAY with i_sel_wr=1 as follows:
- leave r_sel unchanged;
- set o_sel_err=1.
REQ-023 SHALL, on an edge with i_flush=1:
- clear all valid bits and r_fill, regardless of i_en;
- leave data registers unchanged;
- discard the input sample of that edge (stage 1 valid loads 0);
- clear o_sel_err.
REQ-024 SHALL give flush priority over i_en and i_valid; a simultaneous i_sel_wr SHALL still be honoured.
REQ-025 SHALL keep counter r_fill (SW bits):
- increment on each enabled, non-flush edge;
- saturate at MAX_DELAY.
REQ-026 SHALL compute o_primed = (r_fill >= r_sel) combinationally.
- Lowering r_sel can raise o_primed immediately.
- Raising r_sel can drop it.
REQ-027 SHALL make o_valid reflect only the valid bit of stage r_sel, independent of o_primed.
REQ-028 SHALL present o_Taps combinationally from stage registers, unaffected by r_sel.

Reset
REQ-029 SHALL, while i_rst=1, asynchronously set:
- all data registers = 0 and all valid bits = 0;
- r_fill = 0, r_sel = RST_DELAY, o_sel_err = 0.
REQ-030 SHALL therefore give, during reset, o_Dout=0, o_valid=0, o_Taps=0, o_primed=0.
REQ-031 SHALL, when reset asserts mid-operation, discard all in-flight samples; the first enabled edge after deassertion loads stage 1 normally.

Structure
REQ-032 SHALL place the SW width function (clog2) and the default parameter constants in the shared header delay_pkg.
REQ-033 SHALL use one sub-module, delay_stage (BITS data + valid, enable, flush, async reset), instantiated MAX_DELAY times in a generate loop.
REQ-034 SHALL implement the tap mux and the r_sel, r_fill and o_sel_err logic in the top level.

Verification
REQ-035 SHALL cover basic latency: BITS=8, MAX=16, RST_DELAY=4, i_en=1, i_valid=1, feed 0x01,0x02,... -> o_Dout=0x01 with o_valid=1 four edges after 0x01 is sampled; o_primed rises on the same edge.
REQ-036 SHALL cover stall: stream running with delay 4, i_en=0 for 3 cycles -> o_Dout, o_Taps and r_fill frozen; the stream resumes with no gaps or duplicates.
REQ-037 SHALL cover delay switching: at delay 4, i_sel=9 with i_sel_wr -> next cycle o_Dout shows the stage-9 contents and o_primed drops if r_fill<9; i_sel=0 -> r_sel stays 9 and o_sel_err=1.
REQ-038 SHALL cover flush: with stages full, i_flush=1 together with i_valid=1 and i_Din=0xAA -> all valids 0, o_primed=0, o_sel_err cleared; 0xAA never appears with o_valid=1.
REQ-039 SHALL cover mid-stream reset: assert i_rst between clock edges -> outputs 0 immediately; r_sel=RST_DELAY after release.
REQ-040 SHALL cover saturation: 40 enabled cycles with MAX=16 -> r_fill holds at 16, and o_Taps stage k equals the input from k edges earlier.
